// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for one FIFO write port; grant appears 1 cycle after request, datapath is combinational.
// A grant owns the port until last or MAX_BURST beats; backpressure only via fifo_write_ready, almost_full blocks new grants.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write_req,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_write_ready,
    input  logic                          fifo_almost_full,
    output logic                          grant_valid,
    output logic [REQ_ID_W-1:0]           grant_id
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                state_q, state_d;
    logic [REQ_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [REQ_ID_W-1:0]   winner;
    logic [REQ_ID_W-1:0]   grant_inc;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  burst_end;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_q == REQ_ID_W'(k)) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scan offsets from farthest to nearest so the closest valid index after rr_ptr wins.
    always_comb begin
        int                  idx;
        logic [REQ_ID_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        winner = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = REQ_ID_W'(idx);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    assign grant_inc = (grant_id_q == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign xfer      = (state_q == S_BURST) && sel_valid && fifo_write_ready;
    assign burst_end = xfer && (sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if ((|req_valid) && !fifo_almost_full) begin
                    state_d    = S_BURST;
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (burst_end) begin
                    state_d    = S_IDLE;
                    rr_ptr_d   = grant_inc;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked during reset so an abandoned burst cannot sneak in one more beat.
    always_comb begin
        req_ready       = '0;
        fifo_write_req  = 1'b0;
        fifo_write_data = sel_data;
        if ((state_q == S_BURST) && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req_ready[k] = (grant_id_q == REQ_ID_W'(k)) && fifo_write_ready;
            end
            fifo_write_req = sel_valid && fifo_write_ready;
        end
    end

    assign grant_valid = (state_q == S_BURST);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a transaction-level arbiter model.
module tb_fifo_write_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int MB = 16;
    localparam int IW = 2;
    localparam int QD = 1024;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_write_req;
    logic [DW-1:0]     fifo_write_data;
    logic              fifo_write_ready;
    logic              fifo_almost_full;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_write_req   (fifo_write_req),
        .fifo_write_data  (fifo_write_data),
        .fifo_write_ready (fifo_write_ready),
        .fifo_almost_full (fifo_almost_full),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer beat queues: data, last flag, head/tail indices.
    logic [DW-1:0] bd [NR][QD];
    logic          bl [NR][QD];
    int            hd [NR];
    int            tl [NR];
    int            seq;

    logic [NR-1:0] stall;
    logic          rdy, af, rst;

    // Reference arbiter: who owns the port, how many beats so far, where the scan starts.
    bit m_busy;
    int m_gid, m_ptr, m_cnt;

    int checks, errors, cyc;
    bit chk_en, prev_gv;
    int obs_wr, obs_gv, g_n;
    int g_id [64];
    int g_cyc [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            bd[k][tl[k]] = {8'(k), 24'(seq), 32'($urandom)};
            bl[k][tl[k]] = (i == n - 1);
            tl[k]++;
            seq++;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int k = 0; k < NR; k++) if (hd[k] != tl[k]) p = 1'b1;
        return p;
    endfunction

    task automatic cycle();
        logic [NR-1:0] v;
        logic [NR-1:0] tmp;
        logic [NR-1:0] exp_rdy;
        logic          sel_v, exp_wr, lastb, found;
        int            w;
        for (int k = 0; k < NR; k++) begin
            v[k] = (hd[k] != tl[k]) && !stall[k];
            req_last[k] = v[k] ? bl[k][hd[k]] : 1'b0;
            req_data[k*DW +: DW] = v[k] ? bd[k][hd[k]] : '0;
        end
        req_valid        = v;
        fifo_write_ready = rdy;
        fifo_almost_full = af;
        reset            = rst;
        tmp   = v >> m_gid;
        sel_v = tmp[0];
        @(negedge clk);
        exp_wr  = m_busy && !rst && sel_v && rdy;
        exp_rdy = (m_busy && !rst && rdy) ? (NR'(1) << m_gid) : '0;
        if (chk_en) begin
            check("grant_valid", 64'(grant_valid), 64'(m_busy));
            check("grant_id", 64'(grant_id), 64'(m_gid));
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("fifo_write_req", 64'(fifo_write_req), 64'(exp_wr));
            if (exp_wr) check("fifo_write_data", fifo_write_data, bd[m_gid][hd[m_gid]]);
        end
        if (fifo_write_req === 1'b1) obs_wr++;
        if (grant_valid === 1'b1) obs_gv++;
        if (grant_valid === 1'b1 && !prev_gv && g_n < 64) begin
            g_id[g_n]  = int'(grant_id);
            g_cyc[g_n] = cyc;
            g_n++;
        end
        prev_gv = (grant_valid === 1'b1);
        @(posedge clk);
        if (exp_wr) begin
            lastb = bl[m_gid][hd[m_gid]];
            hd[m_gid]++;
            m_cnt++;
            if (lastb || m_cnt == MB) begin
                m_busy = 1'b0;
                m_ptr  = (m_gid + 1) % NR;
                m_cnt  = 0;
            end
        end else if (!m_busy && (|v) && !af && !rst) begin
            found = 1'b0;
            w = 0;
            for (int j = 0; j < NR; j++) begin
                tmp = v >> ((m_ptr + j) % NR);
                if (!found && tmp[0]) begin
                    found = 1'b1;
                    w = (m_ptr + j) % NR;
                end
            end
            m_busy = 1'b1;
            m_gid  = w;
            m_cnt  = 0;
        end
        if (rst) begin
            m_busy = 1'b0;
            m_gid  = 0;
            m_ptr  = 0;
            m_cnt  = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((m_busy || pending()) && n < maxc) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(n < maxc), 64'(1));
    endtask

    task automatic wait_pop(input int k, input int cnt, input int maxc);
        int n;
        n = 0;
        while (hd[k] < cnt && n < maxc) begin
            cycle();
            n++;
        end
        check("wait_beats_timeout", 64'(n < maxc), 64'(1));
    endtask

    task automatic clear_obs();
        obs_wr = 0;
        obs_gv = 0;
        g_n    = 0;
    endtask

    initial begin
        int c0, base;
        checks = 0; errors = 0; cyc = 0; seq = 0;
        chk_en = 1'b0; prev_gv = 1'b0;
        m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        stall = '0; rdy = 1'b1; af = 1'b0; rst = 1'b1;
        for (int k = 0; k < NR; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_write_ready = 1'b1; fifo_almost_full = 1'b0; reset = 1'b1;
        clear_obs();

        // Reset state, then a single 3-beat burst from producer 1.
        do_reset();
        cycle();
        push_burst(1, 3);
        clear_obs();
        c0 = cyc;
        drain(50);
        check("single_writes", 64'(obs_wr), 64'(3));
        check("single_grants", 64'(g_n), 64'(1));
        check("single_gid", 64'(g_id[0]), 64'(1));
        check("single_latency", 64'(g_cyc[0] - c0), 64'(1));
        // rr_ptr now 2: with 0 and 3 both waiting, 3 must win.
        push_burst(0, 1);
        push_burst(3, 1);
        clear_obs();
        drain(50);
        check("rr_after_single", 64'(g_id[0]), 64'(3));
        check("rr_wrap", 64'(g_id[1]), 64'(0));

        // Fairness: every producer continuously valid with 2-beat bursts.
        do_reset();
        for (int k = 0; k < NR; k++) begin
            push_burst(k, 2);
            push_burst(k, 2);
        end
        clear_obs();
        drain(100);
        check("fair_grants", 64'(g_n), 64'(8));
        for (int i = 0; i < 8; i++) check("fair_order", 64'(g_id[i]), 64'(i % NR));
        for (int i = 0; i < 7; i++) check("fair_spacing", 64'(g_cyc[i+1] - g_cyc[i]), 64'(3));

        // MAX_BURST cut: producer 0 has 20 beats, producer 2 waits.
        do_reset();
        push_burst(0, 20);
        push_burst(2, 2);
        clear_obs();
        drain(200);
        check("cut_grants", 64'(g_n), 64'(3));
        check("cut_gid0", 64'(g_id[0]), 64'(0));
        check("cut_gid1", 64'(g_id[1]), 64'(2));
        check("cut_gid2", 64'(g_id[2]), 64'(0));
        check("cut_len", 64'(g_cyc[1] - g_cyc[0]), 64'(MB + 1));
        check("cut_writes", 64'(obs_wr), 64'(22));

        // Backpressure: ready low for 5 cycles mid-burst.
        do_reset();
        push_burst(3, 6);
        base = hd[3];
        wait_pop(3, base + 2, 20);
        rdy = 1'b0;
        clear_obs();
        for (int i = 0; i < 5; i++) cycle();
        check("bp_no_writes", 64'(obs_wr), 64'(0));
        check("bp_grant_held", 64'(obs_gv), 64'(5));
        rdy = 1'b1;
        clear_obs();
        drain(50);
        check("bp_rest", 64'(obs_wr), 64'(4));

        // Almost full blocks arbitration in IDLE.
        do_reset();
        af = 1'b1;
        for (int k = 0; k < NR; k++) push_burst(k, 2);
        clear_obs();
        for (int i = 0; i < 10; i++) cycle();
        check("af_no_grant", 64'(g_n), 64'(0));
        af = 1'b0;
        c0 = cyc;
        drain(100);
        check("af_first_gid", 64'(g_id[0]), 64'(0));
        check("af_latency", 64'(g_cyc[0] - c0), 64'(1));

        // Reset mid-burst abandons the burst; arbitration restarts from producer 0.
        do_reset();
        push_burst(1, 8);
        base = hd[1];
        wait_pop(1, base + 2, 20);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        push_burst(0, 2);
        clear_obs();
        drain(100);
        check("rst_first_gid", 64'(g_id[0]), 64'(0));
        check("rst_second_gid", 64'(g_id[1]), 64'(1));
        check("rst_writes", 64'(obs_wr), 64'(8));

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NR; k++) begin
                if (hd[k] == tl[k] && tl[k] < QD - 40 && $urandom_range(0, 3) == 0)
                    push_burst(k, int'($urandom_range(1, 20)));
                stall[k] = ($urandom_range(0, 7) == 0);
            end
            rdy = ($urandom_range(0, 4) != 0);
            af  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        stall = '0; rdy = 1'b1; af = 1'b0; rst = 1'b0;
        drain(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
